// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the pipelined ALU: operation encodings,
//            bit positions inside the {Z,N,C,V} flags vector, and the
//            controller state type used when the multiplier is built in.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  // Bit positions within flags = {Z,N,C,V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Purpose  : Iterative shift-add multiplier, one multiplier bit per cycle.
//            A start pulse loads the operands; WIDTH iteration cycles follow.
//            done is high during the last iteration cycle and product then
//            carries the complete 2*WIDTH-bit result (the value the
//            accumulator takes at the closing edge), so the caller can
//            capture it on that same edge.
// Ports    : clk, rst (sync, active-high), start, mcand, mplier,
//            done, product
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  // Upper half accumulates partial sums; lower half holds the multiplier
  // bits not yet consumed, shifted right one position per iteration.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_nxt;

  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
    end else if (start && !r_busy) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_mcand <= mcand;
      r_acc   <= {{WIDTH{1'b0}}, mplier};
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(WIDTH - 1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign done    = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign product = w_acc_nxt;

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : One-stage registered ALU with valid/ready handshakes on both
//            sides. Single-cycle ops complete at the transfer edge; when
//            built with macro ALU_MUL_EN, op 10 runs on an iterative
//            multiplier (alu_mul_seq) and the input side stalls until the
//            product is loaded. Without ALU_MUL_EN, op 10 is illegal.
// Ports    : clk, rst (sync, active-high)
//            in_valid/in_ready, op[3:0], input_a/input_b[WIDTH-1:0]
//            out_valid/out_ready, out[WIDTH-1:0], flags[3:0] {Z,N,C,V}, err
// Macro    : ALU_MUL_EN - enables the MUL operation
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  logic             w_xfer;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_err;
  logic [3:0]       w_flags;
  logic             w_is_mul;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_out;
  logic [3:0]       w_mul_flags;

  assign w_xfer = in_valid && in_ready;
  assign w_sh   = input_b[SHW-1:0];

  // Single-cycle datapath; unknown codes fall through to the illegal response.
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (op)
      OP_ADD: begin
        w_sum = {1'b0, input_a} + {1'b0, input_b};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (input_a[WIDTH-1] == input_b[WIDTH-1]) && (w_res[WIDTH-1] != input_a[WIDTH-1]);
      end
      OP_SUB: begin
        // Top bit of the (WIDTH+1)-bit difference is the unsigned borrow.
        w_sum = {1'b0, input_a} - {1'b0, input_b};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (input_a[WIDTH-1] != input_b[WIDTH-1]) && (w_res[WIDTH-1] != input_a[WIDTH-1]);
      end
      OP_AND:  w_res = input_a & input_b;
      OP_OR:   w_res = input_a | input_b;
      OP_XOR:  w_res = input_a ^ input_b;
      OP_SLL:  w_res = input_a << w_sh;
      OP_SRL:  w_res = input_a >> w_sh;
      OP_SRA:  w_res = WIDTH'($signed(input_a) >>> w_sh);
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(input_a) < $signed(input_b))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (input_a < input_b)};
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_Z] = (w_res == '0);
    w_flags[FLAG_N] = w_res[WIDTH-1];
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_V] = w_v;
  end

`ifdef ALU_MUL_EN
  state_t             r_state;
  state_t             w_state_nxt;
  logic [2*WIDTH-1:0] w_product;

  assign w_is_mul = (op == OP_MUL);

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_xfer && w_is_mul),
    .mcand   (input_a),
    .mplier  (input_b),
    .done    (w_mul_done),
    .product (w_product)
  );

  assign w_mul_out = w_product[WIDTH-1:0];

  always_comb begin
    w_mul_flags         = '0;
    w_mul_flags[FLAG_Z] = (w_mul_out == '0);
    w_mul_flags[FLAG_N] = w_mul_out[WIDTH-1];
    w_mul_flags[FLAG_C] = |w_product[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_xfer && w_is_mul) w_state_nxt = ST_MUL;
      ST_MUL:  if (w_mul_done)         w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state != ST_MUL) && (!out_valid || out_ready);
  end
`else
  assign w_is_mul    = 1'b0;
  assign w_mul_done  = 1'b0;
  assign w_mul_out   = '0;
  assign w_mul_flags = '0;
  assign in_ready    = !out_valid || out_ready;
`endif

  // Result registers. A MUL transfer empties them (any previous result is
  // being consumed in that same cycle) until the product arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      flags     <= '0;
      err       <= 1'b0;
    end else if (w_mul_done) begin
      out_valid <= 1'b1;
      out       <= w_mul_out;
      flags     <= w_mul_flags;
      err       <= 1'b0;
    end else if (w_xfer) begin
      if (w_is_mul) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= 1'b1;
        out       <= w_res;
        flags     <= w_flags;
        err       <= w_err;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Self-checking bench for alu_pipe (WIDTH = 16). Directed vector
//            table, handshake corner sequences and a random phase; results
//            are matched in order against a queue of expected records.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] input_a = '0;
  logic [W-1:0] input_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic [3:0]   flags;
  logic         err;

  typedef struct packed {
    logic [15:0] out;
    logic [3:0]  flags;
    logic        err;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    exp_t        e;
  } vec_t;

  exp_t q[$];
  exp_t drv_exp;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic rnd_done = 1'b0;
  vec_t tbl[14];

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .input_a   (input_a),
    .input_b   (input_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: integer arithmetic on widened values.
  function automatic exp_t model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    exp_t        r;
    int          sx, sy, s, sh;
    logic [31:0] p;
    logic        z, n, c, v;
    r  = '0;
    c  = 1'b0;
    v  = 1'b0;
    sx = int'($signed(x));
    sy = int'($signed(y));
    sh = int'(y & 16'h000F);
    case (o)
      4'd0: begin
        s = int'(x) + int'(y);
        r.out = s[15:0];
        c = s[16];
        v = (sx + sy > 32767) || (sx + sy < -32768);
      end
      4'd1: begin
        r.out = x - y;
        c = (x < y);
        v = (sx - sy > 32767) || (sx - sy < -32768);
      end
      4'd2: r.out = x & y;
      4'd3: r.out = x | y;
      4'd4: r.out = x ^ y;
      4'd5: r.out = x << sh;
      4'd6: r.out = x >> sh;
      4'd7: r.out = 16'($signed(x) >>> sh);
      4'd8: r.out = (sx < sy) ? 16'd1 : 16'd0;
      4'd9: r.out = (x < y) ? 16'd1 : 16'd0;
`ifdef ALU_MUL_EN
      4'd10: begin
        p = {16'd0, x} * {16'd0, y};
        r.out = p[15:0];
        c = (p[31:16] != 16'd0);
      end
`endif
      default: r.err = 1'b1;
    endcase
    z = (r.out == 16'd0);
    n = r.out[15];
    r.flags = {z, n, c, v};
    return r;
  endfunction

  // Scoreboard: pop on consumption, push on acceptance (pop first so a
  // freshly accepted request is never matched against the current output).
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got out=%h flags=%b err=%b, none expected", out, flags, err);
        end else begin
          e = q.pop_front();
          check("result", {out, flags, err}, e);
        end
      end
      if (in_valid && in_ready) q.push_back(drv_exp);
    end
  end

  task automatic send(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y, input exp_t e);
    int   cnt;
    logic acc;
    op = o; input_a = x; input_b = y; drv_exp = e; in_valid = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cnt++;
    end while (!acc && cnt < 100);
    in_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required acceptance", cnt);
    end
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while ((q.size() != 0 || out_valid) && cnt < 300) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (cnt >= 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results pending, required 0", q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    logic ok;
    tbl[0]  = '{OP_ADD,  16'hFFFF, 16'h0001, '{16'h0000, 4'b1010, 1'b0}};
    tbl[1]  = '{OP_SUB,  16'h8000, 16'h0001, '{16'h7FFF, 4'b0001, 1'b0}};
    tbl[2]  = '{OP_SRA,  16'h8000, 16'h0004, '{16'hF800, 4'b0100, 1'b0}};
    tbl[3]  = '{OP_AND,  16'hF0F0, 16'h0FF0, '{16'h00F0, 4'b0000, 1'b0}};
    tbl[4]  = '{OP_OR,   16'h1200, 16'h0034, '{16'h1234, 4'b0000, 1'b0}};
    tbl[5]  = '{OP_XOR,  16'hAAAA, 16'hAAAA, '{16'h0000, 4'b1000, 1'b0}};
    tbl[6]  = '{OP_SLL,  16'h0001, 16'h0013, '{16'h0008, 4'b0000, 1'b0}};
    tbl[7]  = '{OP_SRL,  16'h8000, 16'h000F, '{16'h0001, 4'b0000, 1'b0}};
    tbl[8]  = '{OP_SLT,  16'h8000, 16'h0001, '{16'h0001, 4'b0000, 1'b0}};
    tbl[9]  = '{OP_SLTU, 16'h8000, 16'h0001, '{16'h0000, 4'b1000, 1'b0}};
    tbl[10] = '{OP_SUB,  16'h0001, 16'h0002, '{16'hFFFF, 4'b0110, 1'b0}};
    tbl[11] = '{OP_ADD,  16'h7FFF, 16'h0001, '{16'h8000, 4'b0101, 1'b0}};
    tbl[12] = '{4'hF,    16'h1234, 16'h0000, '{16'h0000, 4'b1000, 1'b1}};
    tbl[13] = '{OP_SLL,  16'h0005, 16'h0010, '{16'h0005, 4'b0000, 1'b0}};

    // Reset state, first cycle after deassertion
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_state", {in_ready, out_valid, out, flags, err}, {1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0});

    // Single-cycle latency
    send(OP_ADD, 16'hFFFF, 16'h0001, '{16'h0000, 4'b1010, 1'b0});
    check("add_latency", out_valid, 1'b1);
    drain();

    // Directed table, back-to-back
    for (int i = 0; i < 14; i++) send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
    drain();

    // Backpressure: three ADDs with the consumer stalled
    out_ready = 1'b0;
    send(OP_ADD, 16'd1, 16'd1, '{16'd2, 4'b0000, 1'b0});
    check("bp_in_ready", in_ready, 1'b0);
    fork
      begin
        send(OP_ADD, 16'd2, 16'd2, '{16'd4, 4'b0000, 1'b0});
        send(OP_ADD, 16'd3, 16'd3, '{16'd6, 4'b0000, 1'b0});
      end
    join_none
    repeat (4) @(posedge clk);
    #1;
    check("bp_hold", {out_valid, out, in_ready}, {1'b1, 16'd2, 1'b0});
    out_ready = 1'b1;
    wait fork;
    drain();

    // Reset while a result is held and a transfer is offered
    out_ready = 1'b0;
    send(OP_ADD, 16'd5, 16'd5, '{16'd10, 4'b0000, 1'b0});
    out_ready = 1'b1;
    op = OP_ADD; input_a = 16'd1; input_b = 16'd1; drv_exp = '{16'd2, 4'b0000, 1'b0};
    in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_clear", {in_ready, out_valid, out, flags, err}, {1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_leak", out_valid, 1'b0);

`ifdef ALU_MUL_EN
    // ADD consumed in the same cycle as the MUL transfer, then MUL latency
    send(OP_ADD, 16'd1, 16'd2, '{16'd3, 4'b0000, 1'b0});
    send(OP_MUL, 16'd300, 16'd300, '{16'h5F90, 4'b0010, 1'b0});
    check("mul_drop", out_valid, 1'b0);
    ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (out_valid || in_ready) ok = 1'b0;
      @(posedge clk);
      #1;
    end
    check("mul_busy", ok, 1'b1);
    check("mul_latency", {out_valid, out}, {1'b1, 16'h5F90});
    drain();

    // Reset five cycles into a MUL aborts it
    send(OP_MUL, 16'd7, 16'd9, model(OP_MUL, 16'd7, 16'd9));
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ok = 1'b1;
    repeat (30) begin
      if (out_valid) ok = 1'b0;
      @(posedge clk);
      #1;
    end
    check("mul_abort", ok, 1'b1);
    send(OP_ADD, 16'd2, 16'd3, '{16'd5, 4'b0000, 1'b0});
    drain();
`else
    // Without the multiplier op 10 is illegal
    send(OP_MUL, 16'h1234, 16'h0003, '{16'h0000, 4'b1000, 1'b1});
    check("op10_latency", {out_valid, err}, {1'b1, 1'b1});
    drain();
`endif

    // Random ops with a randomly stalling consumer
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [3:0]  ro;
          logic [15:0] rx, ry;
          ro = 4'($urandom_range(0, 15));
          rx = 16'($urandom);
          ry = 16'($urandom);
          send(ro, rx, ry, model(ro, rx, ry));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
